queue_display_ctrl: RTL and testbench

//  Button-driven FIFO demo block: generalised, parametrised successor of the single-button 4-bit x 8 queue display.
//  Two debounced buttons (push, pop) replace the shared button + push_pop select; width and depth are parameters.

---
 rtl/queue_display_ctrl.sv | 155 +++++++++++++++
 tb/tb_queue_display_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/queue_display_ctrl.sv
// Two-button FIFO demo: debounced push/pop, occupancy count and a scanned hex 7-segment display.
// Build option QUEUE_ERR_FLAG_EN adds a sticky err output for push-when-full / pop-when-empty.
module queue_display_ctrl #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 8,
    parameter int DB_CYCLES = 250000,
    parameter int SCAN_DIV  = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    btn_push,
    input  logic                    btn_pop,
    input  logic [DATA_W-1:0]       data_in,
    output logic [DATA_W-1:0]       data_out,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
`ifdef QUEUE_ERR_FLAG_EN
    output logic                    err,
`endif
    output logic [6:0]              seg,
    output logic [DATA_W/4:0]       an
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NIB   = DATA_W / 4;
    localparam int NDIG  = NIB + 1;
    localparam int IDX_W = $clog2(NDIG);
    localparam int DIV_W = $clog2(SCAN_DIV + 1);
    localparam int DB_W  = $clog2(DB_CYCLES + 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    logic [1:0] btn_raw;
    logic [1:0] pulse;
    assign btn_raw = {btn_pop, btn_push};

    // Synchroniser resets high so a button held through reset is seen as already pressed;
    // arming only after a synced low means that press never produces an action.
    for (genvar b = 0; b < 2; b++) begin : g_db
        logic            sync_p0, sync_p1, level, armed, pls;
        logic [DB_W-1:0] db_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_p0 <= 1'b1;
                sync_p1 <= 1'b1;
                level   <= 1'b0;
                armed   <= 1'b0;
                pls     <= 1'b0;
                db_cnt  <= '0;
            end else begin
                sync_p0 <= btn_raw[b];
                sync_p1 <= sync_p0;
                armed   <= armed | ~sync_p1;
                pls     <= 1'b0;
                if (sync_p1 == level) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                    db_cnt <= '0;
                    level  <= sync_p1;
                    pls    <= sync_p1 & armed;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end

        assign pulse[b] = pls;
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              push_act, pop_act, do_push, do_pop;

    assign push_act = pulse[0] & enable;
    assign pop_act  = pulse[1] & enable;
    assign do_pop   = pop_act & ~empty;
    // A push is allowed into a full queue only when a pop frees the slot in the same cycle.
    assign do_push  = push_act & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign data_out = empty ? '0 : mem[rd_ptr];

`ifdef QUEUE_ERR_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err <= 1'b0;
        else if ((push_act & ~pop_act & full) | (pop_act & ~push_act & empty))
            err <= 1'b1;
    end
`endif

    logic [IDX_W-1:0]  scan_idx, idx_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [DATA_W-1:0] shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_idx <= '0;
            div_cnt  <= '0;
        end else begin
            scan_idx <= idx_nxt;
            div_cnt  <= div_nxt;
        end
    end

    always_comb begin
        div_nxt = div_cnt + 1'b1;
        idx_nxt = scan_idx;
        if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_nxt = '0;
            idx_nxt = (scan_idx == IDX_W'(NDIG - 1)) ? '0 : scan_idx + 1'b1;
        end
    end

    // Top digit shows the count; the lower digits show the head entry, blanked when empty.
    always_comb begin
        an           = '0;
        an[scan_idx] = 1'b1;
        shifted      = data_out >> {scan_idx, 2'b00};
        if (scan_idx == IDX_W'(NIB))
            seg = hex7(4'(count));
        else if (empty)
            seg = 7'h00;
        else
            seg = hex7(shifted[3:0]);
    end

endmodule

// File: tb/tb_queue_display_ctrl.sv
// Randomised and directed bench for queue_display_ctrl against a queue-based reference model.
module tb_queue_display_ctrl;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int DBC    = 4;
    localparam int SDIV   = 3;
    localparam int NDIG   = DATA_W / 4 + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b1;
    logic              btn_push = 1'b0;
    logic              btn_pop = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic [DATA_W-1:0] data_out;
    logic [3:0]        count;
    logic              full, empty;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
`ifdef QUEUE_ERR_FLAG_EN
    logic              err;
`endif

    queue_display_ctrl #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DB_CYCLES(DBC), .SCAN_DIV(SDIV)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_push(btn_push), .btn_pop(btn_pop), .data_in(data_in),
        .data_out(data_out), .count(count), .full(full), .empty(empty),
`ifdef QUEUE_ERR_FLAG_EN
        .err(err),
`endif
        .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int q[$];
    bit err_exp = 1'b0;
    int edges;

    logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Clocks seen since reset released; the scan position follows from it.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_state(input string tag);
        int idx;
        logic [6:0] seg_exp;
        idx = (edges / SDIV) % NDIG;
        chk({tag, ".count"}, count, q.size());
        chk({tag, ".empty"}, empty, q.size() == 0);
        chk({tag, ".full"}, full, q.size() == DEPTH);
        chk({tag, ".data_out"}, data_out, (q.size() != 0) ? q[0] : 0);
        chk({tag, ".an"}, an, 1 << idx);
        if (idx == NDIG - 1)     seg_exp = seg_ref[q.size()];
        else if (q.size() == 0)  seg_exp = 7'h00;
        else                     seg_exp = seg_ref[(q[0] >> (4 * idx)) & 15];
        chk({tag, ".seg"}, seg, seg_exp);
`ifdef QUEUE_ERR_FLAG_EN
        chk({tag, ".err"}, err, err_exp);
`endif
    endtask

    function automatic void model_apply(input bit p, input bit o, input bit en, input int d);
        if (!en) return;
        if ((p && !o && q.size() == DEPTH) || (o && !p && q.size() == 0)) err_exp = 1'b1;
        if (o && q.size() > 0) begin
            if (p) q.push_back(d);
            void'(q.pop_front());
        end else if (p && q.size() < DEPTH) begin
            q.push_back(d);
        end
    endfunction

    task automatic press(input bit p, input bit o, input bit en, input int d);
        data_in  = DATA_W'(d);
        enable   = en;
        btn_push = p;
        btn_pop  = o;
        step(20);
        btn_push = 1'b0;
        btn_pop  = 1'b0;
        step(20);
        enable = 1'b1;
        model_apply(p, o, en, d);
    endtask

    task automatic bounce(input int n);
        repeat (n) begin
            btn_push = 1'b1;
            step($urandom_range(1, 3));
            btn_push = 1'b0;
            step($urandom_range(1, 3));
        end
    endtask

    initial begin
        #1;
        check_state("reset");
        step(2);
        reset = 1'b0;
        step(1);
        check_state("post_reset");

        press(1, 0, 1, 3);
        press(1, 0, 1, 7);
        press(1, 0, 1, 'hA);
        check_state("push3");
        chk("push3.count_const", count, 3);
        chk("push3.head_const", data_out, 3);
        press(0, 1, 1, 0);
        chk("pop1.head_const", data_out, 7);
        chk("pop1.count_const", count, 2);
        press(0, 1, 1, 0);
        press(0, 1, 1, 0);
        check_state("drained");

        for (int i = 0; i < 8; i++) press(1, 0, 1, i);
        check_state("fill8");
        chk("fill8.full_const", full, 1);
        press(1, 0, 1, 9);
        check_state("push_when_full");
        chk("push_when_full.head_const", data_out, 0);

        for (int i = 0; i < 3; i++) press(0, 1, 1, 0);
        press(1, 0, 1, 'hA);
        press(1, 0, 1, 'hB);
        press(1, 0, 1, 'hC);
        check_state("wrapped");
        for (int i = 0; i < 8; i++) begin
            check_state("drain_order");
            press(0, 1, 1, 0);
        end
        check_state("drain_done");
        press(0, 1, 1, 0);
        check_state("pop_when_empty");

        press(1, 1, 1, 5);
        check_state("both_empty");
        chk("both_empty.head_const", data_out, 5);
        for (int i = 0; i < 7; i++) press(1, 0, 1, i + 1);
        press(1, 1, 1, 'hE);
        check_state("both_full");
        chk("both_full.head_const", data_out, 1);

        for (int i = 0; i < 8; i++) begin
            step(1);
            check_state("scan");
        end

        press(0, 1, 0, 0);
        step(10);
        check_state("enable_low");

        while (q.size() > 2) press(0, 1, 1, 0);
        bounce(6);
        step(20);
        check_state("glitch_only");
        data_in = 4'h6;
        bounce(4);
        press(1, 0, 1, 6);
        check_state("glitch_then_hold");

        repeat (60) begin
            int op;
            op = $urandom_range(0, 5);
            case (op)
                0, 1: press(1, 0, 1, $urandom_range(0, 15));
                2:    press(0, 1, 1, 0);
                3:    press(1, 1, 1, $urandom_range(0, 15));
                4:    press(1, 0, 0, $urandom_range(0, 15));
                default: press(0, 1, 0, 0);
            endcase
            check_state("random");
        end

        while (q.size() < 4) press(1, 0, 1, q.size());
        data_in  = 4'h2;
        btn_push = 1'b1;
        step(3);
        #3 reset = 1'b1;
        #1;
        q.delete();
        err_exp = 1'b0;
        chk("async_reset.count", count, 0);
        chk("async_reset.an", an, 1);
        chk("async_reset.empty", empty, 1);
        chk("async_reset.data_out", data_out, 0);
        step(2);
        reset = 1'b0;
        step(30);
        check_state("held_through_reset");
        btn_push = 1'b0;
        step(20);
        check_state("released_after_reset");
        press(1, 0, 1, 'hD);
        check_state("repress_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
